// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback path.
// Widths, FSM encoding, round-robin source encoding, buffered write entry.
package rf_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int NREG   = 2 ** ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry writeback holding buffer with valid/ready input and pop from the arbiter.
// Latency 1 cycle (load on accept edge); ready = enable & (empty | popping this edge).
module wb_hold_buf
  import rf_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      en_i,
  input  logic      flush_i,
  input  logic      pop_i,
  input  logic      in_vld_i,
  input  wb_entry_t in_dat_i,
  output logic      in_rdy_o,
  output logic      full_o,
  output wb_entry_t entry_o
);

  logic      full_q, full_d;
  wb_entry_t entry_q, entry_d;

  // Ready depends only on registered state, never on in_vld_i.
  assign in_rdy_o = en_i & (~full_q | pop_i);

  always_comb begin
    full_d  = full_q;
    entry_d = entry_q;
    if (flush_i) begin
      full_d = 1'b0;
    end else if (in_vld_i && in_rdy_o) begin
      full_d  = 1'b1;
      entry_d = in_dat_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      full_q  <= full_d;
      entry_q <= entry_d;
    end
  end

  assign full_o  = full_q;
  assign entry_o = entry_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (A) and load (B) writeback.
// Latency: accept edge -> RF_WRITE pulse after next edge; sources stall via READY while buffered and not granted.
module rf_write_arbiter #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 3,
  parameter int CLR_CYCLES = 2
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic                 A_VALID,
  input  logic [ADDR_W-1:0]    A_ADDR,
  input  logic [DATA_W-1:0]    A_DATA,
  output logic                 A_READY,
  input  logic                 B_VALID,
  input  logic [ADDR_W-1:0]    B_ADDR,
  input  logic [DATA_W-1:0]    B_DATA,
  output logic                 B_READY,
  input  logic                 CLR_REQ,
  output logic                 RF_WRITE,
  output logic [ADDR_W-1:0]    RF_INADDRESS,
  output logic [DATA_W-1:0]    RF_IN,
  output logic                 RF_RESET,
  output logic [2**ADDR_W-1:0] PEND,
  output logic                 BUSY
);
  import rf_pkg::*;

  localparam int NR    = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(CLR_CYCLES + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  src_e              rr_q, rr_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_addr_q;
  logic [DATA_W-1:0] rf_data_q;

  logic      run, clr_go;
  logic      full_a, full_b, gnt_a, gnt_b;
  wb_entry_t in_a, in_b, ent_a, ent_b, ent_sel;
  logic [NR-1:0] pend;

  assign run    = (state_q == ST_RUN);
  assign clr_go = run & CLR_REQ;
  assign in_a   = '{addr: A_ADDR, data: A_DATA};
  assign in_b   = '{addr: B_ADDR, data: B_DATA};

  wb_hold_buf u_buf_a (
    .clk(CLK), .rst_n(RESETN), .en_i(run), .flush_i(clr_go), .pop_i(gnt_a),
    .in_vld_i(A_VALID), .in_dat_i(in_a), .in_rdy_o(A_READY), .full_o(full_a), .entry_o(ent_a)
  );

  wb_hold_buf u_buf_b (
    .clk(CLK), .rst_n(RESETN), .en_i(run), .flush_i(clr_go), .pop_i(gnt_b),
    .in_vld_i(B_VALID), .in_dat_i(in_b), .in_rdy_o(B_READY), .full_o(full_b), .entry_o(ent_b)
  );

  // Grants come from registered state only, so READY never sees VALID combinationally.
  assign gnt_a   = run & full_a & (~full_b | (rr_q == SRC_A));
  assign gnt_b   = run & full_b & (~full_a | (rr_q == SRC_B));
  assign ent_sel = gnt_a ? ent_a : ent_b;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    rf_we_d = (gnt_a | gnt_b) & ~clr_go;
    case (state_q)
      ST_CLEAR: begin
        if (CLR_REQ) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(CLR_CYCLES - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (CLR_REQ) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (full_a && full_b) begin
          rr_d = gnt_a ? SRC_B : SRC_A;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= '0;
      rr_q      <= SRC_A;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      rf_we_q <= rf_we_d;
      if (rf_we_d) begin
        rf_addr_q <= ent_sel.addr;
        rf_data_q <= ent_sel.data;
      end
    end
  end

  always_comb begin
    pend = '0;
    for (int r = 0; r < NR; r++) begin
      pend[r] = run & ((full_a & (ent_a.addr == ADDR_W'(r))) |
                       (full_b & (ent_b.addr == ADDR_W'(r))) |
                       (rf_we_q & (rf_addr_q == ADDR_W'(r))));
    end
  end

  assign RF_WRITE     = rf_we_q;
  assign RF_INADDRESS = rf_addr_q;
  assign RF_IN        = rf_data_q;
  assign RF_RESET     = ~run;
  assign BUSY         = ~run;
  assign PEND         = pend;

endmodule
